rvfi_check_sched: RTL
=====================

Name: rvfi_check_sched

Overview:
Scheduler that decides when the per-instruction checker runs. Monitors the RVFI retirement channels and waits for the retirement whose rvfi_order equals a programmed target. In that same cycle it drives a one-hot per-channel check strobe, then reports the outcome: done, timeout, missed or duplicate. Sits between the formal testbench wrapper and the NRET instruction-check instances, one check input per channel.

Parameters:
NRET, 1, number of retirement channels.
ORDER_W, 64, width of each rvfi_order field.
TMO_W, 16, width of the timeout counter.

Ports:
clock  in  1  single clock.
resetn  in  1  asynchronous, active-low reset.
cfg_start  in  1  pulse; arms the scheduler (honoured in IDLE/DONE/ERROR only).
cfg_target  in  ORDER_W  order number to check, sampled on cfg_start.
cfg_timeout  in  TMO_W  cycle budget, sampled on cfg_start; 0 = no timeout.
rvfi_valid  in  NRET  per-channel retire valid.
rvfi_order  in  NRET*ORDER_W  per-channel order, channel i at [i*ORDER_W +: ORDER_W].
check  out  NRET  one-hot check strobe to checker channel i.
busy  out  1  high in ARMED.
done  out  1  high in DONE.
err  out  2  0 none, 1 timeout, 2 missed, 3 duplicate; valid in ERROR.
chk_chan  out  $clog2(NRET)+1  channel that was checked, registered.
retire_cnt  out  16  retirements seen while ARMED, saturating.

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE; check=0, busy=0, done=0, err=0, chk_chan=0, retire_cnt=0; latched target and timer cleared.
- States: IDLE, ARMED, DONE, ERROR.
- IDLE/DONE/ERROR + cfg_start:
  - next state ARMED.
  - latch target and timeout.
  - clear retire_cnt, err, chk_chan.
- cfg_start while ARMED: ignored.
- Per-channel predicates in ARMED:
  - match[i] = rvfi_valid[i] && order[i]==target.
  - late[i] = rvfi_valid[i] && order[i] > target (unsigned compare).
- check is combinational, zero latency: check[i] = ARMED && match[i] && (popcount(match)==1). It must coincide with the retiring cycle because the checker is combinational.
- Transitions out of ARMED, evaluated in priority order:
  1. popcount(match)>=2 → ERROR, err=3, check all zero.
  2. popcount(match)==1 → DONE, chk_chan=i.
  3. any late[i] → ERROR, err=2 (target skipped).
  4. timer expiry → ERROR, err=1.
  5. otherwise stay ARMED.
- Match and late in the same cycle on different channels: match wins, go to DONE.
- Timer:
  - loaded with cfg_timeout; decrements every ARMED cycle.
  - expiry = timer==1 while decrementing and no match/late this cycle.
  - cfg_timeout=0 disables timeout entirely.
  - a match on the expiry cycle still goes to DONE.
- retire_cnt: += popcount(rvfi_valid) each ARMED cycle, saturating at 0xFFFF. Frozen outside ARMED.
- resetn asserted mid-ARMED: immediate return to IDLE; check drops asynchronously with state.
- cfg_start in the same cycle as a match, while in DONE: new arm takes effect next cycle; the match is not checked.
- NRET=1: duplicate is impossible; the err=3 path is synthesised away.

Decomposition:
- Package rvfi_check_sched_pkg holds:
  - state enum (IDLE, ARMED, DONE, ERROR).
  - err code constants ERR_NONE, ERR_TMO, ERR_MISS, ERR_DUP.
- One sub-module, rvfi_chan_match:
  - pure combinational.
  - inputs: rvfi_valid/order vectors and target.
  - outputs: match vector, late vector, match count, encoded index of the lowest match.

Test Plan:
- Arm target=5, timeout=0; single channel retires orders 3,4,5 on consecutive cycles → check[0]=1 only in the order-5 cycle; done=1 next cycle; retire_cnt=3; err=0.
- Arm target=7, timeout=4; no retirements → ERROR on the 4th ARMED cycle, err=1; check never high.
- Arm target=10; retire order 9, then order 11 → ERROR, err=2, check never high, retire_cnt=2.
- NRET=2, arm target=20; same cycle ch0 order 20 and ch1 order 21 → check=2'b01, DONE, chk_chan=0. Then a separate run with both channels at order 20 → check=00, err=3.
- Arm target=2, retire order 2 and assert resetn=0 the same cycle → outputs reset immediately, state IDLE, done=0. After release, cfg_start re-arms correctly.
- timeout=3 with order-target retiring on the expiry cycle → DONE, err=0.

Source files
------------

// File: rtl/rvfi_check_sched_pkg.sv
// Shared types for the RVFI check scheduler.
// Contents:
//   state_t - scheduler state (IDLE, ARMED, DONE, ERROR)
//   ERR_*   - outcome codes reported on err
package rvfi_check_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TMO  = 2'd1;
  localparam logic [1:0] ERR_MISS = 2'd2;
  localparam logic [1:0] ERR_DUP  = 2'd3;

endpackage

// File: rtl/rvfi_chan_match.sv
// Per-channel comparison of retiring orders against the programmed target.
// Purely combinational.
// Ports:
//   rvfi_valid - per-channel retire valid
//   rvfi_order - per-channel order, channel i at [i*ORDER_W +: ORDER_W]
//   target     - order number being searched for
//   match      - channel retires exactly the target
//   late       - channel retires an order beyond the target (unsigned)
//   match_cnt  - number of matching channels
//   match_idx  - index of the lowest matching channel (0 if none)
module rvfi_chan_match
  import rvfi_check_sched_pkg::*;
#(
  parameter int NRET    = 1,
  parameter int ORDER_W = 64,
  parameter int CW      = $clog2(NRET) + 1
) (
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [ORDER_W-1:0]      target,
  output logic [NRET-1:0]         match,
  output logic [NRET-1:0]         late,
  output logic [CW-1:0]           match_cnt,
  output logic [CW-1:0]           match_idx
);

  // Compare every channel, count the hits and priority-encode the lowest one.
  // The encoder walks from the top channel down so the lowest index wins.
  always_comb begin
    match     = '0;
    late      = '0;
    match_cnt = '0;
    match_idx = '0;
    for (int i = 0; i < NRET; i++) begin
      match[i] = rvfi_valid[i] && (rvfi_order[i*ORDER_W +: ORDER_W] == target);
      late[i]  = rvfi_valid[i] && (rvfi_order[i*ORDER_W +: ORDER_W] > target);
      if (match[i]) match_cnt = match_cnt + CW'(1);
    end
    for (int i = NRET - 1; i >= 0; i--) begin
      if (match[i]) match_idx = CW'(i);
    end
  end

endmodule

// File: rtl/rvfi_check_sched.sv
// Scheduler deciding in which cycle the per-instruction checker runs.
// Waits for the retirement whose order equals a programmed target, strobes the
// matching checker channel in that same cycle and reports the outcome.
// Ports:
//   clock, resetn  - clock, asynchronous active-low reset
//   cfg_start      - arm pulse (ignored while ARMED)
//   cfg_target     - target order, sampled on an accepted cfg_start
//   cfg_timeout    - cycle budget, sampled on an accepted cfg_start; 0 = none
//   rvfi_valid     - per-channel retire valid
//   rvfi_order     - per-channel order, channel i at [i*ORDER_W +: ORDER_W]
//   check          - one-hot, zero-latency checker strobe
//   busy / done    - in ARMED / in DONE
//   err            - 0 none, 1 timeout, 2 missed, 3 duplicate
//   chk_chan       - channel that was checked
//   retire_cnt     - retirements seen while ARMED, saturating
module rvfi_check_sched
  import rvfi_check_sched_pkg::*;
#(
  parameter int NRET    = 1,
  parameter int ORDER_W = 64,
  parameter int TMO_W   = 16
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      cfg_start,
  input  logic [ORDER_W-1:0]        cfg_target,
  input  logic [TMO_W-1:0]          cfg_timeout,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*ORDER_W-1:0]   rvfi_order,
  output logic [NRET-1:0]           check,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  output logic [$clog2(NRET):0]     chk_chan,
  output logic [15:0]               retire_cnt
);

  localparam int CW = $clog2(NRET) + 1;

  state_t             state_q, state_d;
  logic [ORDER_W-1:0] target_q;
  logic [TMO_W-1:0]   timer_q;
  logic [1:0]         err_q, err_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic [15:0]        cnt_q;

  logic [NRET-1:0]    match, late;
  logic [CW-1:0]      match_cnt, match_idx;
  logic               armed, start_ok, single, multi, expire;
  logic [16:0]        valid_cnt, cnt_sum;

  rvfi_chan_match #(
    .NRET    (NRET),
    .ORDER_W (ORDER_W),
    .CW      (CW)
  ) u_match (
    .rvfi_valid (rvfi_valid),
    .rvfi_order (rvfi_order),
    .target     (target_q),
    .match      (match),
    .late       (late),
    .match_cnt  (match_cnt),
    .match_idx  (match_idx)
  );

  assign armed    = (state_q == ARMED);
  assign start_ok = cfg_start && !armed;
  // Comparing against 1 keeps the duplicate test meaningful when CW is 1 bit,
  // where it simply folds to zero for a single channel.
  assign single   = (match_cnt == CW'(1));
  assign multi    = (match_cnt > CW'(1));
  // A timer of 0 never reaches 1, so cfg_timeout=0 disables expiry.
  assign expire   = (timer_q == TMO_W'(1)) && !(|match) && !(|late);

  // The checker is combinational, so the strobe must be combinational too and
  // depends on the state register, dropping at once on an async reset.
  assign check      = (armed && single) ? match : '0;
  assign busy       = armed;
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign chk_chan   = chan_q;
  assign retire_cnt = cnt_q;

  // Number of channels retiring this cycle, widened so the saturating add
  // below can see the carry.
  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < NRET; i++) begin
      valid_cnt = valid_cnt + 17'(rvfi_valid[i]);
    end
    cnt_sum = {1'b0, cnt_q} + valid_cnt;
  end

  // Next-state logic. Outcomes out of ARMED are prioritised duplicate, match,
  // missed, timeout; a match therefore beats a late channel and a timer expiry
  // in the same cycle.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    chan_d  = chan_q;
    case (state_q)
      ARMED: begin
        if (multi) begin
          state_d = ERROR;
          err_d   = ERR_DUP;
        end else if (single) begin
          state_d = DONE;
          chan_d  = match_idx;
        end else if (|late) begin
          state_d = ERROR;
          err_d   = ERR_MISS;
        end else if (expire) begin
          state_d = ERROR;
          err_d   = ERR_TMO;
        end
      end
      default: begin
        if (cfg_start) begin
          state_d = ARMED;
          err_d   = ERR_NONE;
          chan_d  = '0;
        end
      end
    endcase
  end

  // State, outcome and configuration registers. Target and timer are captured
  // only on an accepted arm; the timer counts down every ARMED cycle unless it
  // was programmed as 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      err_q    <= ERR_NONE;
      chan_q   <= '0;
      target_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      chan_q  <= chan_d;
      if (start_ok) begin
        target_q <= cfg_target;
        timer_q  <= cfg_timeout;
      end else if (armed && (timer_q != '0)) begin
        timer_q <= timer_q - TMO_W'(1);
      end
    end
  end

  // Retirement counter: cleared on arm, accumulates only while ARMED and
  // sticks at 0xFFFF once the sum carries out.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if (armed) begin
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule
